nios_adc_key_pio_irq: RTL and testbench



---
 rtl/nios_adc_pio_pkg.sv | 24 ++
 rtl/nios_adc_key_debounce.sv | 56 +++++
 rtl/nios_adc_key_pio_irq.sv | 93 +++++++++
 tb/tb_nios_adc_key_pio_irq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/nios_adc_pio_pkg.sv
// rtl/nios_adc_pio_pkg.sv - register offsets, edge encodings and clog2 helper for the key PIO
package nios_adc_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
  localparam logic [1:0] ADDR_RSVD     = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nios_adc_key_debounce.sv
// rtl/nios_adc_key_debounce.sv - one key channel: two-flop synchroniser, hold-time debouncer, delayed copy
module nios_adc_key_debounce
  import nios_adc_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_raw_i,
  output logic stable_o,
  output logic stable_prev_o
);

  localparam int CW = clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          stable_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised level disagrees with the
  // accepted one, so it tops out at CNT_MAX and never wraps.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q       <= IDLE_LEVEL;
      sync2_q       <= IDLE_LEVEL;
      stable_q      <= IDLE_LEVEL;
      stable_prev_q <= IDLE_LEVEL;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= in_raw_i;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
    end
  end

  assign stable_o      = stable_q;
  assign stable_prev_o = stable_prev_q;

endmodule

// File: rtl/nios_adc_key_pio_irq.sv
// rtl/nios_adc_key_pio_irq.sv - debounced push-button PIO with sticky edge capture and maskable IRQ
module nios_adc_key_pio_irq
  import nios_adc_pio_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable_w, stable_prev_w;
  logic [WIDTH-1:0] edge_hit, edge_hit_q;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] w1c_clr;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    nios_adc_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (IDLE_LEVEL)
    ) u_debounce (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_raw_i     (in_port[gi]),
      .stable_o     (stable_w[gi]),
      .stable_prev_o(stable_prev_w[gi])
    );
  end

  always_comb begin
    edge_hit = '0;
    if (EDGE_TYPE == int'(EDGE_RISE)) begin
      edge_hit = ~stable_prev_w & stable_w;
    end else if (EDGE_TYPE == int'(EDGE_FALL)) begin
      edge_hit = stable_prev_w & ~stable_w;
    end else begin
      edge_hit = stable_prev_w ^ stable_w;
    end
  end

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // A new edge is OR-ed in after the clear so it survives a same-cycle W1C.
  always_comb begin
    irq_mask_d = irq_mask_q;
    w1c_clr    = '0;
    if (wr_en && address == ADDR_IRQ_MASK) irq_mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_EDGE_CAP) w1c_clr = writedata[WIDTH-1:0];
    edge_cap_d = (edge_cap_q & ~w1c_clr) | edge_hit_q;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:     readdata_d[WIDTH-1:0] = stable_w;
      ADDR_IRQ_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE_CAP: readdata_d[WIDTH-1:0] = edge_cap_q;
      default:       readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      edge_hit_q <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
    end else begin
      edge_hit_q <= edge_hit;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_nios_adc_key_pio_irq.sv
// tb/tb_nios_adc_key_pio_irq.sv - vector table, corner sequences and random run against a history-window model
module tb_nios_adc_key_pio_irq;

  localparam int W  = 3;
  localparam int DC = 4;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [W-1:0] in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  nios_adc_key_pio_irq #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(1), .IDLE_LEVEL(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: raw input seen two edges late; a level is accepted once the last DC
  // seen samples all disagree with it; a fall sets capture two edges later.
  logic [W-1:0] m_raw1, m_raw2, m_stable, m_sa1, m_sa2, m_cap, m_mask;
  logic [31:0]  m_rd;
  logic [W-1:0] hist[$];

  task automatic model_step();
    logic [W-1:0] seen, new_st, cap_set, clr;
    bit all_diff;
    if (!reset_n) begin
      m_raw1 = '1; m_raw2 = '1; hist.delete();
      m_stable = '1; m_sa1 = '1; m_sa2 = '1;
      m_cap = '0; m_mask = '0; m_rd = '0;
    end else begin
      seen = m_raw2; m_raw2 = m_raw1; m_raw1 = in_port;
      hist.push_back(seen);
      if (hist.size() > DC) void'(hist.pop_front());
      new_st = m_stable;
      if (hist.size() == DC) begin
        for (int b = 0; b < W; b++) begin
          all_diff = 1'b1;
          foreach (hist[j]) if (hist[j][b] == m_stable[b]) all_diff = 1'b0;
          if (all_diff) new_st[b] = ~m_stable[b];
        end
      end
      cap_set = m_sa2 & ~m_sa1;
      case (address)
        2'd0: m_rd = {29'b0, m_stable};
        2'd1: m_rd = {29'b0, m_mask};
        2'd3: m_rd = {29'b0, m_cap};
        default: m_rd = 32'h0;
      endcase
      clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      if (chipselect && !write_n && address == 2'd1) m_mask = writedata[W-1:0];
      m_cap = (m_cap & ~clr) | cap_set;
      m_sa2 = m_sa1; m_sa1 = m_stable; m_stable = new_st;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("rd_model", readdata, m_rd);
    check("irq_model", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
  endtask

  task automatic bus(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    address = a; chipselect = cs; write_n = wn; writedata = wd;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic        rst_n;
    logic [2:0]  in;
    logic [1:0]  addr;
    logic        cs;
    logic        wr_n;
    logic [31:0] wd;
    int          ncyc;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{1'b0, 3'b010, 2'd0, 1'b0, 1'b1, 32'h0, 3, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 3'b010, 2'd0, 1'b0, 1'b1, 32'h0, 1, 32'h7, 1'b0};
    vecs[2]  = '{1'b1, 3'b010, 2'd0, 1'b0, 1'b1, 32'h0, 5, 32'h7, 1'b0};
    vecs[3]  = '{1'b1, 3'b010, 2'd0, 1'b0, 1'b1, 32'h0, 1, 32'h2, 1'b0};
    vecs[4]  = '{1'b1, 3'b010, 2'd1, 1'b1, 1'b0, 32'h4, 1, 32'h0, 1'b1};
    vecs[5]  = '{1'b1, 3'b010, 2'd3, 1'b0, 1'b1, 32'h0, 1, 32'h5, 1'b1};
    vecs[6]  = '{1'b1, 3'b010, 2'd3, 1'b1, 1'b0, 32'h4, 1, 32'h5, 1'b0};
    vecs[7]  = '{1'b1, 3'b010, 2'd3, 1'b0, 1'b1, 32'h0, 1, 32'h1, 1'b0};
    vecs[8]  = '{1'b1, 3'b010, 2'd1, 1'b1, 1'b0, 32'h1, 1, 32'h4, 1'b1};
    vecs[9]  = '{1'b1, 3'b010, 2'd1, 1'b0, 1'b1, 32'h0, 1, 32'h1, 1'b1};
    vecs[10] = '{1'b1, 3'b000, 2'd0, 1'b0, 1'b1, 32'h0, 3, 32'h2, 1'b1};
    vecs[11] = '{1'b1, 3'b010, 2'd0, 1'b0, 1'b1, 32'h0, 6, 32'h2, 1'b1};
    vecs[12] = '{1'b1, 3'b010, 2'd3, 1'b0, 1'b1, 32'h0, 1, 32'h1, 1'b1};
    vecs[13] = '{1'b1, 3'b111, 2'd3, 1'b0, 1'b1, 32'h0, 8, 32'h1, 1'b1};
    vecs[14] = '{1'b1, 3'b111, 2'd3, 1'b1, 1'b0, 32'h1, 1, 32'h1, 1'b0};
    vecs[15] = '{1'b1, 3'b110, 2'd0, 1'b0, 1'b1, 32'h0, 6, 32'h7, 1'b0};
    vecs[16] = '{1'b1, 3'b110, 2'd0, 1'b0, 1'b1, 32'h0, 1, 32'h6, 1'b0};
    vecs[17] = '{1'b1, 3'b110, 2'd3, 1'b0, 1'b1, 32'h0, 1, 32'h0, 1'b1};
    vecs[18] = '{1'b1, 3'b110, 2'd3, 1'b0, 1'b1, 32'h0, 1, 32'h1, 1'b1};

    reset_n = 1'b0; in_port = 3'b010; bus(2'd0, 1'b0, 1'b1, 32'h0);
    m_raw1 = '1; m_raw2 = '1; m_stable = '1; m_sa1 = '1; m_sa2 = '1;
    m_cap = '0; m_mask = '0; m_rd = '0;
    @(negedge clk);

    foreach (vecs[i]) begin
      reset_n = vecs[i].rst_n; in_port = vecs[i].in;
      bus(vecs[i].addr, vecs[i].cs, vecs[i].wr_n, vecs[i].wd);
      run(vecs[i].ncyc);
      check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
    end

    // Release, clear, then a W1C of bit0 landing on the edge that sets bit0.
    in_port = 3'b111; bus(2'd0, 1'b0, 1'b1, 32'h0); run(8);
    bus(2'd3, 1'b1, 1'b0, 32'h7); run(1);
    check("collide_pre_irq", {31'b0, irq}, 32'h0);
    in_port = 3'b110; bus(2'd0, 1'b0, 1'b1, 32'h0); run(7);
    bus(2'd3, 1'b1, 1'b0, 32'h1); run(1);
    check("collide_irq", {31'b0, irq}, 32'h1);
    bus(2'd3, 1'b0, 1'b1, 32'h0); run(1);
    check("collide_cap", readdata, 32'h1);

    // Reset two cycles into a press.
    in_port = 3'b111; bus(2'd0, 1'b0, 1'b1, 32'h0); run(8);
    bus(2'd3, 1'b1, 1'b0, 32'h7); run(1);
    in_port = 3'b110; bus(2'd0, 1'b0, 1'b1, 32'h0); run(2);
    reset_n = 1'b0; run(2);
    check("midrst_rd", readdata, 32'h0);
    reset_n = 1'b1; in_port = 3'b111; bus(2'd3, 1'b0, 1'b1, 32'h0); run(12);
    check("midrst_cap", readdata, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);

    // Reserved address ignores writes and reads zero.
    bus(2'd1, 1'b1, 1'b0, 32'h1); run(1);
    bus(2'd2, 1'b1, 1'b0, 32'hFFFF_FFFF); run(1);
    bus(2'd2, 1'b0, 1'b1, 32'h0); run(1);
    check("rsvd_rd", readdata, 32'h0);
    bus(2'd1, 1'b0, 1'b1, 32'h0); run(1);
    check("rsvd_mask", readdata, 32'h1);
    bus(2'd3, 1'b0, 1'b1, 32'h0); run(1);
    check("rsvd_cap", readdata, 32'h0);
    bus(2'd0, 1'b0, 1'b1, 32'h0); run(1);
    check("rsvd_data", readdata, 32'h7);

    for (int c = 0; c < 2500; c++) begin
      reset_n = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 5) == 0) in_port = W'($urandom);
      address = 2'($urandom);
      chipselect = $urandom_range(0, 1);
      write_n = ($urandom_range(0, 3) != 0);
      writedata = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
